// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing the single-port system RAM between the BIOS loader and the CPU.
// Registers the RAM command and steers each read response back to the port that issued it.
module ram_arbiter #(
  parameter int ADDR_WIDTH   = 31,
  parameter int DATA_WIDTH   = 31,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_booted,
  input  logic                  i_b_req,
  input  logic                  i_b_we,
  input  logic [3:0]            i_b_be,
  input  logic [ADDR_WIDTH:0]   i_b_addr,
  input  logic [DATA_WIDTH:0]   i_b_wdata,
  output logic                  o_b_gnt,
  output logic                  o_b_rvalid,
  output logic [DATA_WIDTH:0]   o_b_rdata,
  input  logic                  i_c_req,
  input  logic                  i_c_we,
  input  logic [3:0]            i_c_be,
  input  logic [ADDR_WIDTH:0]   i_c_addr,
  input  logic [DATA_WIDTH:0]   i_c_wdata,
  output logic                  o_c_gnt,
  output logic                  o_c_rvalid,
  output logic [DATA_WIDTH:0]   o_c_rdata,
  output logic                  o_ram_read_req,
  output logic                  o_ram_write_enable,
  output logic [3:0]            o_ram_byte_enable,
  output logic [ADDR_WIDTH:0]   o_ram_addr,
  output logic [DATA_WIDTH:0]   o_ram_write_data,
  input  logic [DATA_WIDTH:0]   i_ram_read_data
);

  logic                  last;
  logic                  b_gnt;
  logic                  c_gnt;
  logic                  c_elig;
  logic                  any_gnt;
  logic                  sel_we;
  logic [3:0]            sel_be;
  logic [ADDR_WIDTH:0]   sel_addr;
  logic [DATA_WIDTH:0]   sel_wdata;
  logic [READ_LATENCY:0] tag_valid;
  logic [READ_LATENCY:0] tag_owner;

  assign c_elig  = i_c_req & i_booted;
  assign any_gnt = b_gnt | c_gnt;
  assign o_b_gnt = b_gnt;
  assign o_c_gnt = c_gnt;

  // Tie goes to whichever port was not granted last.
  always_comb begin
    b_gnt = 1'b0;
    c_gnt = 1'b0;
    if (i_b_req && c_elig) begin
      if (last) begin
        b_gnt = 1'b1;
      end else begin
        c_gnt = 1'b1;
      end
    end else if (i_b_req) begin
      b_gnt = 1'b1;
    end else if (c_elig) begin
      c_gnt = 1'b1;
    end else begin
      b_gnt = 1'b0;
      c_gnt = 1'b0;
    end
  end

  always_comb begin
    sel_we    = i_b_we;
    sel_be    = i_b_be;
    sel_addr  = i_b_addr;
    sel_wdata = i_b_wdata;
    if (c_gnt) begin
      sel_we    = i_c_we;
      sel_be    = i_c_be;
      sel_addr  = i_c_addr;
      sel_wdata = i_c_wdata;
    end else begin
      sel_we    = i_b_we;
      sel_be    = i_b_be;
      sel_addr  = i_b_addr;
      sel_wdata = i_b_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last               <= 1'b1;
      o_ram_read_req     <= 1'b0;
      o_ram_write_enable <= 1'b0;
      o_ram_byte_enable  <= 4'b0000;
      o_ram_addr         <= '0;
      o_ram_write_data   <= '0;
    end else begin
      o_ram_read_req     <= any_gnt & ~sel_we;
      o_ram_write_enable <= any_gnt & sel_we;
      if (any_gnt) begin
        last       <= c_gnt;
        o_ram_addr <= sel_addr;
        if (sel_we) begin
          o_ram_byte_enable <= sel_be;
          o_ram_write_data  <= sel_wdata;
        end
      end
    end
  end

  // Stage k is visible k+1 cycles after the grant; the last stage lines up with RAM data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_valid <= '0;
      tag_owner <= '0;
    end else begin
      tag_valid <= {tag_valid[READ_LATENCY-1:0], any_gnt & ~sel_we};
      tag_owner <= {tag_owner[READ_LATENCY-1:0], c_gnt};
    end
  end

  always_comb begin
    o_b_rvalid = tag_valid[READ_LATENCY] & ~tag_owner[READ_LATENCY];
    o_c_rvalid = tag_valid[READ_LATENCY] & tag_owner[READ_LATENCY];
    if (o_b_rvalid) begin
      o_b_rdata = i_ram_read_data;
    end else begin
      o_b_rdata = '0;
    end
    if (o_c_rvalid) begin
      o_c_rdata = i_ram_read_data;
    end else begin
      o_c_rdata = '0;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: one instance at READ_LATENCY=1 and one at READ_LATENCY=3
// sharing the stimulus, each with a behavioural RAM of matching latency.
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        booted;
  logic        b_req, b_we, c_req, c_we;
  logic [3:0]  b_be, c_be;
  logic [31:0] b_addr, b_wdata, c_addr, c_wdata;

  logic        b_gnt, b_rvalid, c_gnt, c_rvalid, ram_rd, ram_we;
  logic [31:0] b_rdata, c_rdata, ram_addr, ram_wdata, ram_rdata;
  logic [3:0]  ram_be;
  logic        b_gnt2, b_rvalid2, c_gnt2, c_rvalid2, ram_rd2, ram_we2;
  logic [31:0] b_rdata2, c_rdata2, ram_addr2, ram_wdata2, ram_rdata2;
  logic [3:0]  ram_be2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ram_arbiter #(.ADDR_WIDTH(31), .DATA_WIDTH(31), .READ_LATENCY(1)) dut (
    .clk(clk), .rst(rst), .i_booted(booted),
    .i_b_req(b_req), .i_b_we(b_we), .i_b_be(b_be), .i_b_addr(b_addr), .i_b_wdata(b_wdata),
    .o_b_gnt(b_gnt), .o_b_rvalid(b_rvalid), .o_b_rdata(b_rdata),
    .i_c_req(c_req), .i_c_we(c_we), .i_c_be(c_be), .i_c_addr(c_addr), .i_c_wdata(c_wdata),
    .o_c_gnt(c_gnt), .o_c_rvalid(c_rvalid), .o_c_rdata(c_rdata),
    .o_ram_read_req(ram_rd), .o_ram_write_enable(ram_we), .o_ram_byte_enable(ram_be),
    .o_ram_addr(ram_addr), .o_ram_write_data(ram_wdata), .i_ram_read_data(ram_rdata));

  ram_arbiter #(.ADDR_WIDTH(31), .DATA_WIDTH(31), .READ_LATENCY(3)) dut3 (
    .clk(clk), .rst(rst), .i_booted(booted),
    .i_b_req(b_req), .i_b_we(b_we), .i_b_be(b_be), .i_b_addr(b_addr), .i_b_wdata(b_wdata),
    .o_b_gnt(b_gnt2), .o_b_rvalid(b_rvalid2), .o_b_rdata(b_rdata2),
    .i_c_req(c_req), .i_c_we(c_we), .i_c_be(c_be), .i_c_addr(c_addr), .i_c_wdata(c_wdata),
    .o_c_gnt(c_gnt2), .o_c_rvalid(c_rvalid2), .o_c_rdata(c_rdata2),
    .o_ram_read_req(ram_rd2), .o_ram_write_enable(ram_we2), .o_ram_byte_enable(ram_be2),
    .o_ram_addr(ram_addr2), .o_ram_write_data(ram_wdata2), .i_ram_read_data(ram_rdata2));

  // Behavioural RAM: unwritten words read as C0DE00xx where xx is the word index.
  logic [31:0]  mem [0:255];
  logic [255:0] written = '0;
  logic [31:0]  rpipe1;
  logic [31:0]  rpipe3 [0:2];

  function automatic logic [31:0] init_word(input logic [7:0] idx);
    return 32'hC0DE_0000 | {24'h000000, idx};
  endfunction

  function automatic logic [31:0] word_at(input logic [7:0] idx);
    return written[idx] ? mem[idx] : init_word(idx);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int k = 0; k < 4; k++) if (be[k]) r[8*k +: 8] = wd[8*k +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    if (ram_we) begin
      mem[ram_addr[9:2]]     <= merge(word_at(ram_addr[9:2]), ram_wdata, ram_be);
      written[ram_addr[9:2]] <= 1'b1;
    end
    rpipe1    <= word_at(ram_addr[9:2]);
    rpipe3[0] <= word_at(ram_addr2[9:2]);
    rpipe3[1] <= rpipe3[0];
    rpipe3[2] <= rpipe3[1];
  end

  assign ram_rdata  = rpipe1;
  assign ram_rdata2 = rpipe3[2];

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    b_req = 1'b0; b_we = 1'b0; b_be = 4'b0000; b_addr = 32'h0; b_wdata = 32'h0;
    c_req = 1'b0; c_we = 1'b0; c_be = 4'b0000; c_addr = 32'h0; c_wdata = 32'h0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; booted = 1'b1;
    idle_inputs();
    b_req = 1'b1; c_req = 1'b1;
    @(negedge clk);
    total++; if ({ram_rd, ram_we, ram_be} !== 6'b0) begin bad++; $display("FAIL reset_strobes got=%b want=000000", {ram_rd, ram_we, ram_be}); end
    total++; if (ram_addr !== 32'h0 || ram_wdata !== 32'h0) begin bad++; $display("FAIL reset_addr_data got=%h/%h want=0/0", ram_addr, ram_wdata); end
    total++; if ({b_rvalid, c_rvalid} !== 2'b00 || b_rdata !== 32'h0 || c_rdata !== 32'h0) begin bad++; $display("FAIL reset_resp got=%b %h %h want=00 0 0", {b_rvalid, c_rvalid}, b_rdata, c_rdata); end
    total++; if ({b_gnt, c_gnt} !== 2'b10) begin bad++; $display("FAIL reset_tie got=%b want=10", {b_gnt, c_gnt}); end
    next_cycle();
    rst = 1'b0;
    idle_inputs();
  endtask

  task automatic test_boot_only();
    booted = 1'b0;
    b_req = 1'b1; b_we = 1'b1; b_be = 4'b1111; b_addr = 32'h10; b_wdata = 32'hDEADBEEF;
    c_req = 1'b1; c_we = 1'b0; c_addr = 32'h10;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++; if ({b_gnt, c_gnt} !== {(i == 0), 1'b0}) begin bad++; $display("FAIL boot_only_gnt cyc=%0d got=%b want=%b", i, {b_gnt, c_gnt}, {(i == 0), 1'b0}); end
      if (i == 1) begin
        total++; if ({ram_we, ram_rd, ram_be} !== 6'b101111) begin bad++; $display("FAIL boot_only_cmd got=%b want=101111", {ram_we, ram_rd, ram_be}); end
        total++; if (ram_addr !== 32'h10 || ram_wdata !== 32'hDEADBEEF) begin bad++; $display("FAIL boot_only_addr got=%h/%h want=10/deadbeef", ram_addr, ram_wdata); end
      end
      if (i == 2) begin
        total++; if (ram_we !== 1'b0) begin bad++; $display("FAIL boot_only_we_drop got=%b want=0", ram_we); end
      end
      next_cycle();
      b_req = 1'b0;
    end
    idle_inputs();
  endtask

  task automatic test_round_robin();
    do_reset();
    booted = 1'b1;
    b_req = 1'b1; b_addr = 32'h40;
    c_req = 1'b1; c_addr = 32'h80;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i < 4) begin
        total++; if ({b_gnt, c_gnt} !== {(i % 2 == 0), (i % 2 == 1)}) begin bad++; $display("FAIL rr_gnt cyc=%0d got=%b want=%b", i, {b_gnt, c_gnt}, {(i % 2 == 0), (i % 2 == 1)}); end
      end
      if (i < 2) begin
        total++; if ({b_rvalid, c_rvalid} !== 2'b00 || b_rdata !== 32'h0 || c_rdata !== 32'h0) begin bad++; $display("FAIL rr_early cyc=%0d got=%b %h %h want=00 0 0", i, {b_rvalid, c_rvalid}, b_rdata, c_rdata); end
      end else begin
        total++; if ({b_rvalid, c_rvalid} !== {(i % 2 == 0), (i % 2 == 1)}) begin bad++; $display("FAIL rr_rvalid cyc=%0d got=%b want=%b", i, {b_rvalid, c_rvalid}, {(i % 2 == 0), (i % 2 == 1)}); end
        total++; if (b_rdata !== ((i % 2 == 0) ? 32'hC0DE0010 : 32'h0) || c_rdata !== ((i % 2 == 1) ? 32'hC0DE0020 : 32'h0)) begin bad++; $display("FAIL rr_rdata cyc=%0d got=%h/%h", i, b_rdata, c_rdata); end
      end
      next_cycle();
      if (i == 3) idle_inputs();
    end
  endtask

  task automatic test_latency3();
    logic [31:0] exp;
    idle_inputs();
    booted = 1'b1;
    for (int i = 0; i < 4; i++) next_cycle();
    for (int i = 0; i < 8; i++) begin
      c_req  = (i < 3);
      c_addr = 32'(i * 4);
      @(negedge clk);
      exp = (i >= 4 && i <= 6) ? init_word(8'(i - 4)) : 32'h0;
      total++; if (c_gnt2 !== (i < 3)) begin bad++; $display("FAIL lat3_gnt cyc=%0d got=%b want=%b", i, c_gnt2, (i < 3)); end
      total++; if (c_rvalid2 !== (i >= 4 && i <= 6) || b_rvalid2 !== 1'b0) begin bad++; $display("FAIL lat3_rvalid cyc=%0d got=%b%b want=0%b", i, b_rvalid2, c_rvalid2, (i >= 4 && i <= 6)); end
      total++; if (c_rdata2 !== exp) begin bad++; $display("FAIL lat3_rdata cyc=%0d got=%h want=%h", i, c_rdata2, exp); end
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_boot_toggle();
    booted = 1'b0;
    b_req = 1'b1; b_addr = 32'h10;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) begin
        total++; if ({b_gnt, c_gnt} !== 2'b10) begin bad++; $display("FAIL toggle_gnt got=%b want=10", {b_gnt, c_gnt}); end
      end
      total++; if ({b_rvalid, c_rvalid} !== {(i == 2), 1'b0}) begin bad++; $display("FAIL toggle_rvalid cyc=%0d got=%b want=%b0", i, {b_rvalid, c_rvalid}, (i == 2)); end
      if (i == 2) begin
        total++; if (b_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL toggle_rdata got=%h want=deadbeef", b_rdata); end
      end
      next_cycle();
      b_req = 1'b0; booted = 1'b1;
    end
    idle_inputs();
  endtask

  task automatic test_byte_enable();
    booted = 1'b1;
    b_addr = 32'h20; b_wdata = 32'h12345678; b_be = 4'b0010;
    for (int i = 0; i < 7; i++) begin
      b_req = (i == 0 || i == 4);
      b_we  = (i == 0);
      @(negedge clk);
      total++; if (b_gnt !== (i == 0 || i == 4)) begin bad++; $display("FAIL be_gnt cyc=%0d got=%b want=%b", i, b_gnt, (i == 0 || i == 4)); end
      total++; if (ram_we !== (i == 1)) begin bad++; $display("FAIL be_we cyc=%0d got=%b want=%b", i, ram_we, (i == 1)); end
      total++; if ({b_rvalid, c_rvalid} !== {(i == 6), 1'b0}) begin bad++; $display("FAIL be_rvalid cyc=%0d got=%b want=%b0", i, {b_rvalid, c_rvalid}, (i == 6)); end
      if (i == 1) begin
        total++; if (ram_be !== 4'b0010 || ram_addr !== 32'h20 || ram_rd !== 1'b0) begin bad++; $display("FAIL be_cmd got=%b %h %b want=0010 20 0", ram_be, ram_addr, ram_rd); end
      end
      if (i == 6) begin
        total++; if (b_rdata !== 32'hC0DE5608) begin bad++; $display("FAIL be_readback got=%h want=c0de5608", b_rdata); end
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_reset_midflight();
    booted = 1'b1;
    c_req = 1'b1; c_addr = 32'h80;
    @(negedge clk);
    total++; if (c_gnt !== 1'b1) begin bad++; $display("FAIL mid_gnt got=%b want=1", c_gnt); end
    next_cycle();
    c_req = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    total++; if (ram_rd !== 1'b0 || {b_rvalid, c_rvalid} !== 2'b00) begin bad++; $display("FAIL mid_rst got=%b %b want=0 00", ram_rd, {b_rvalid, c_rvalid}); end
    next_cycle();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++; if ({b_rvalid, c_rvalid} !== 2'b00) begin bad++; $display("FAIL mid_stale cyc=%0d got=%b want=00", i, {b_rvalid, c_rvalid}); end
      next_cycle();
    end
    b_req = 1'b1; c_req = 1'b1; b_addr = 32'h40;
    @(negedge clk);
    total++; if ({b_gnt, c_gnt} !== 2'b10) begin bad++; $display("FAIL mid_first_tie got=%b want=10", {b_gnt, c_gnt}); end
    next_cycle();
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_boot_only();
    test_round_robin();
    test_latency3();
    test_boot_toggle();
    test_byte_enable();
    test_reset_midflight();
    for (int i = 0; i < 3; i++) next_cycle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Shares the single-port system RAM between the BIOS loader (serial boot/debug commands) and the CPU data port. Until the BIOS reports boot complete, only the BIOS may access RAM. Afterwards both requesters are served round-robin. The block registers the RAM command, tracks in-flight reads, and routes each read response back to the requester that issued it.

## Interface

Parameters:
- ADDR_WIDTH, 31, MSB index of address buses (bus width ADDR_WIDTH+1)
- DATA_WIDTH, 31, MSB index of data buses (bus width DATA_WIDTH+1)
- READ_LATENCY, 1, cycles from o_ram_read_req to valid i_ram_read_data; legal 1..4

Ports:
- clk  input  1  system clock; one clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- i_booted  input  1  BIOS boot-complete flag; 0 = BIOS-only, 1 = shared
- i_b_req  input  1  BIOS request, held until o_b_gnt
- i_b_we  input  1  1 = write, 0 = read
- i_b_be  input  4  BIOS byte enables (writes only)
- i_b_addr  input  ADDR_WIDTH+1  BIOS address
- i_b_wdata  input  DATA_WIDTH+1  BIOS write data
- o_b_gnt  output  1  BIOS request accepted this cycle (combinational)
- o_b_rvalid  output  1  BIOS read data valid, one-cycle pulse
- o_b_rdata  output  DATA_WIDTH+1  BIOS read data, 0 when o_b_rvalid=0
- i_c_req, i_c_we, i_c_be, i_c_addr, i_c_wdata  input  as BIOS  CPU request fields
- o_c_gnt, o_c_rvalid, o_c_rdata  output  as BIOS  CPU responses
- o_ram_read_req  output  1  RAM read strobe (registered)
- o_ram_write_enable  output  1  RAM write strobe (registered)
- o_ram_byte_enable  output  4  RAM byte enables (registered)
- o_ram_addr  output  ADDR_WIDTH+1  RAM address (registered)
- o_ram_write_data  output  DATA_WIDTH+1  RAM write data (registered)
- i_ram_read_data  input  DATA_WIDTH+1  RAM read data

## Operation

- At most one grant per cycle. A request is a single-cycle transfer on the cycle its gnt is 1. A requester holds all request fields stable until it sees gnt.
- Eligibility:
  - i_booted=0: only the BIOS is eligible; o_c_gnt is forced 0.
  - i_booted=1: both requesters are eligible.
- Priority register `last`: 0 = BIOS last granted, 1 = CPU last granted.
  - Resets to 1, so the BIOS wins the first tie.
  - On a tie, the requester that was not `last` wins.
  - `last` updates on every grant.
- A single eligible requester is granted immediately. No idle bubbles; back-to-back grants are allowed every cycle.
- A granted request is captured into the RAM command registers:
  - Read: o_ram_read_req=1, o_ram_write_enable=0.
  - Write: o_ram_write_enable=1, o_ram_read_req=0, and o_ram_byte_enable=i_x_be.
  - With no grant, both strobes are 0. Address, data and byte-enable registers hold their last value.
- Read routing: a tag pipeline of READ_LATENCY+1 stages, each holding {valid, owner}.
  - A stage is loaded when a read is granted.
  - When the tag exits, the owner's rvalid pulses and its rdata = i_ram_read_data. The other port's rvalid is 0 and its rdata is 0.
- An i_booted change never cancels in-flight reads. Each read returns to the port that issued it. If i_booted falls, a CPU request already granted still completes.
- Writes produce no response.

## Timing

- Reset (asynchronous assert, synchronous deassert by the clock domain):
  - o_ram_* = 0, all rvalid = 0, all rdata = 0.
  - Tag pipeline cleared and `last` = 1.
  - Gnt outputs remain combinational but evaluate with booted-gating and `last` = 1.
- Reset mid-operation: in-flight reads are discarded and no rvalid is issued for them. RAM strobes drop immediately.
- Grant at cycle N:
  - RAM command visible at N+1.
  - Read data and rvalid at N+1+READ_LATENCY, so the round trip is 2 cycles with READ_LATENCY=1.
- Throughput: one command per cycle. Reads from alternating owners are returned in issue order, one per cycle.
- Simultaneous request and response on the same port is allowed; the port may be granted in the same cycle its rvalid pulses.

## Test plan

- i_booted=0; CPU reads 0x10 and BIOS writes 0xDEADBEEF to 0x10 with be=4'b1111, both in the same cycle -> only o_b_gnt=1. o_c_gnt stays 0 indefinitely. RAM write at 0x10 appears the next cycle.
- i_booted=1; both ports hold read requests for 4 cycles, starting from reset -> grant sequence B,C,B,C. rvalid alternates b,c,b,c starting 2 cycles after the first grant, with each rdata equal to the RAM model's content at that port's address.
- READ_LATENCY=3; CPU issues back-to-back reads to 0x0,0x4,0x8 -> o_c_rvalid is high for 3 consecutive cycles starting 4 cycles after the first grant, with data in issue order.
- BIOS read granted, then i_booted toggles 0→1 on the next cycle -> o_b_rvalid still pulses 2 cycles after the grant, and o_c_rvalid stays 0.
- rst asserted one cycle after a CPU read grant -> o_ram_read_req=0 and all rvalid=0 immediately. No rvalid appears after rst releases. The first tie after reset grants the BIOS.
- BIOS write with be=4'b0010 to 0x20 -> o_ram_byte_enable=4'b0010 and o_ram_write_enable=1 for exactly one cycle, with no rvalid on either port.
